// File: rtl/bpsk_modulator.sv
// bpsk_modulator: BPSK carrier source, free-running DDS with per-symbol polarity from a one-deep bit buffer
// Ports: sys_clk/sys_rst_n clock and async active-low reset; bit_data/bit_valid/bit_ready bit handshake;
// d_out signed 8-bit carrier sample; sym_strobe pulse 2 cycles ahead of a new symbol on d_out; busy running or holding.
module bpsk_modulator #(
  parameter int PHASE_W = 32,
  parameter logic [PHASE_W-1:0] FCW = PHASE_W'(85899346),
  parameter int CYCLES_PER_SYMBOL = 100
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              bit_data,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic signed [7:0] d_out,
  output logic              sym_strobe,
  output logic              busy
);
  localparam int CW = CYCLES_PER_SYMBOL > 1 ? $clog2(CYCLES_PER_SYMBOL) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_SYMBOL - 1);
  localparam logic [6:0] QSIN [0:64] = '{
    0, 3, 6, 9, 12, 16, 19, 22, 25, 28, 31, 34, 37, 40, 43, 46,
    49, 51, 54, 57, 60, 63, 65, 68, 71, 73, 76, 78, 81, 83, 85, 88,
    90, 92, 94, 96, 98, 100, 102, 104, 106, 107, 109, 111, 112, 113, 115, 116,
    117, 118, 120, 121, 122, 122, 123, 124, 125, 125, 126, 126, 126, 127, 127, 127,
    127};
  typedef enum logic {IDLE, RUN} state_t;
  state_t              r_state, w_state_nx;
  logic [PHASE_W-1:0]  r_phase;
  logic [PHASE_W:0]    w_sum;
  logic                w_wrap, w_load, w_accept, w_hold_nx;
  logic [CW-1:0]       r_cyc, w_cyc_nx;
  logic                r_hold_valid, r_hold_bit, r_cur_bit, w_cur_bit_nx;
  logic [7:0]          w_idx;
  logic [6:0]          w_qaddr, w_mag;
  logic signed [7:0]   w_lut, r_lut;
  logic                r_en, r_neg;
  assign w_sum     = {1'b0, r_phase} + {1'b0, FCW};
  assign w_wrap    = w_sum[PHASE_W];
  assign w_accept  = bit_valid & bit_ready;
  // accept and load never coincide: accepting requires an empty buffer
  assign w_hold_nx = w_accept | (r_hold_valid & ~w_load);
  always_comb begin
    w_state_nx   = r_state;
    w_cyc_nx     = r_cyc;
    w_cur_bit_nx = r_cur_bit;
    w_load       = 1'b0;
    if (w_wrap) begin
      if (r_state == IDLE || r_cyc == LAST) begin
        w_load       = r_hold_valid;
        w_state_nx   = r_hold_valid ? RUN : IDLE;
        w_cyc_nx     = '0;
        w_cur_bit_nx = r_hold_valid ? r_hold_bit : r_cur_bit;
      end else
        w_cyc_nx = r_cyc + CW'(1);
    end
  end
  // quarter-wave lookup: mirror the address in odd quadrants, negate in the lower half
  assign w_idx   = r_phase[PHASE_W-1 -: 8];
  assign w_qaddr = w_idx[6] ? 7'd64 - {1'b0, w_idx[5:0]} : {1'b0, w_idx[5:0]};
  assign w_mag   = QSIN[w_qaddr];
  assign w_lut   = w_idx[7] ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_phase      <= '0;
      r_state      <= IDLE;
      r_cyc        <= '0;
      r_cur_bit    <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_bit   <= 1'b0;
      bit_ready    <= 1'b0;
      busy         <= 1'b0;
      sym_strobe   <= 1'b0;
      r_lut        <= '0;
      r_en         <= 1'b0;
      r_neg        <= 1'b0;
      d_out        <= '0;
    end else begin
      r_phase      <= w_sum[PHASE_W-1:0];
      r_state      <= w_state_nx;
      r_cyc        <= w_cyc_nx;
      r_cur_bit    <= w_cur_bit_nx;
      r_hold_valid <= w_hold_nx;
      r_hold_bit   <= w_accept ? bit_data : r_hold_bit;
      bit_ready    <= ~w_hold_nx;
      busy         <= (w_state_nx == RUN) | w_hold_nx;
      sym_strobe   <= w_load;
      r_lut        <= w_lut;
      r_en         <= r_state == RUN;
      r_neg        <= ~r_cur_bit;
      d_out        <= r_en ? (r_neg ? -r_lut : r_lut) : '0;
    end
  end
endmodule
